clk_freq_divider: RTL and testbench

// Derives the 1 MHz timing clock for the DDS datapath from the 100 MHz board clock.
// A free-running modulo-DIV counter drives a registered, glitch-free divided output
// at ~50 % duty cycle.
// The block sits at the top of the clock tree, between the board oscillator and the
// DDS phase accumulator / DAC timing logic.
//

---
 rtl/clk_freq_divider.sv | 67 ++++++
 tb/tb_clk_freq_divider.sv | 138 +++++++++++++
 2 files changed

// File: rtl/clk_freq_divider.sv
// Integer clock divider: free-running modulo-DIV counter feeding a registered
// ~50 % duty output. Includes a small checker that guards the counter range.

module clk_freq_divider_chk #(
    parameter int DIV   = 100,
    parameter int CNT_W = 7
) (
    input logic             clk_100MHz,
    input logic             rst,
    input logic [CNT_W-1:0] cnt
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    // Counter must stay inside 0..DIV-1 whenever the divider is running
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            assert (cnt <= LAST)
                else $error("clk_freq_divider: cnt %0d out of range", cnt);
        end
    end
endmodule

module clk_freq_divider #(
    parameter int DIV   = 100,
    parameter int CNT_W = 7
) (
    input  logic clk_100MHz,
    input  logic rst,
    output logic clk_1MHz
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2);

    if (DIV < 2 || (2 ** CNT_W) < DIV) begin : g_param_err
        $error("clk_freq_divider: illegal DIV=%0d / CNT_W=%0d", DIV, CNT_W);
    end

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    // Next count: wraps silently at DIV-1
    always_comb begin
        cnt_next_s = cnt_r;
        if (cnt_r == LAST) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Counter and output flop; output is taken straight from the flop so it cannot glitch
    always_ff @(posedge clk_100MHz) begin
        if (!rst) begin
            cnt_r    <= {CNT_W{1'b0}};
            clk_1MHz <= 1'b0;
        end else begin
            cnt_r    <= cnt_next_s;
            clk_1MHz <= (cnt_next_s >= HALF);
        end
    end

    clk_freq_divider_chk #(.DIV(DIV), .CNT_W(CNT_W)) u_chk (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .cnt        (cnt_r)
    );
endmodule

// File: tb/tb_clk_freq_divider.sv
// Self-checking bench: divider instances at DIV = 100, 2, 3, 7 against an
// edges-since-reset arithmetic model, plus hand-computed edge/duty checks.

module tb_clk_freq_divider;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic o100, o2, o3, o7;

    int vectors    = 0;
    int miscompares = 0;
    int k = 0;          // active edges seen since reset was last released
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    clk_freq_divider u_dut (.clk_100MHz(clk), .rst(rst), .clk_1MHz(o100));
    clk_freq_divider #(.DIV(2), .CNT_W(1)) u_d2 (.clk_100MHz(clk), .rst(rst), .clk_1MHz(o2));
    clk_freq_divider #(.DIV(3), .CNT_W(2)) u_d3 (.clk_100MHz(clk), .rst(rst), .clk_1MHz(o3));
    clk_freq_divider #(.DIV(7), .CNT_W(3)) u_d7 (.clk_100MHz(clk), .rst(rst), .clk_1MHz(o7));

    function automatic logic exp_out(input int n, input int div);
        return ((n % div) >= (div / 2));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: count active edges since release
    always @(posedge clk) begin
        k <= rst ? k + 1 : 0;
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_div100", {31'd0, o100}, {31'd0, exp_out(k, 100)});
            check("out_div2",   {31'd0, o2},   {31'd0, exp_out(k, 2)});
            check("out_div3",   {31'd0, o3},   {31'd0, exp_out(k, 3)});
            check("out_div7",   {31'd0, o7},   {31'd0, exp_out(k, 7)});
            check("cnt_div100", 32'(u_dut.cnt_r), 32'(k % 100));
        end
    end

    initial begin
        logic cur [4];
        logic prv [4];
        int   run [4];
        int   hi  [4];
        int   lo  [4];
        int   rises;
        int   exp_hi [4];
        int   exp_lo [4];
        exp_hi = '{50, 1, 2, 4};
        exp_lo = '{50, 1, 1, 3};

        // Reset hold
        rst = 1'b0;
        step(1);
        chk_en = 1'b1;
        step(19);
        check("reset_out", {31'd0, o100}, 32'd0);
        check("reset_cnt", 32'(u_dut.cnt_r), 32'd0);

        // First edge timing after release
        rst = 1'b1;
        step(49);
        check("edge49_low",  {31'd0, o100}, 32'd0);
        step(1);
        check("edge50_high", {31'd0, o100}, 32'd1);
        step(49);
        check("edge99_high", {31'd0, o100}, 32'd1);
        step(1);
        check("edge100_low", {31'd0, o100}, 32'd0);

        // 1000 cycles: count rises and measure phase lengths
        cur = '{o100, o2, o3, o7};
        prv = cur;
        rises = 0;
        for (int j = 0; j < 4; j++) begin
            run[j] = 0; hi[j] = 0; lo[j] = 0;
        end
        for (int i = 0; i < 1000; i++) begin
            step(1);
            cur = '{o100, o2, o3, o7};
            for (int j = 0; j < 4; j++) begin
                if (cur[j] === prv[j]) begin
                    run[j]++;
                end else begin
                    if (prv[j] === 1'b1) hi[j] = run[j];
                    else                 lo[j] = run[j];
                    if (j == 0 && cur[j] === 1'b1) rises++;
                    run[j] = 1;
                end
                prv[j] = cur[j];
            end
        end
        check("rises_1000", 32'(rises), 32'd10);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("high_len_%0d", j), 32'(hi[j]), 32'(exp_hi[j]));
            check($sformatf("low_len_%0d", j),  32'(lo[j]), 32'(exp_lo[j]));
        end

        // Mid-period reset at cnt = 70
        step(70);
        check("mid_cnt70_high", {31'd0, o100}, 32'd1);
        rst = 1'b0;
        step(1);
        check("mid_reset_low", {31'd0, o100}, 32'd0);
        rst = 1'b1;
        step(49);
        check("mid_edge49_low", {31'd0, o100}, 32'd0);
        step(1);
        check("mid_edge50_high", {31'd0, o100}, 32'd1);

        // Randomised reset pulses over a long run
        for (int c = 0; c < 15000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                step($urandom_range(1, 3));
                rst = 1'b1;
            end
            step(1);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
